// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory req/ack, decode hand-off,
// and the execute-stage redirect/halt controls.
//
// Handshakes:
//   imem_req/imem_ack: the sequencer raises imem_req with a stable imem_addr
//   and holds both until a cycle in which imem_ack is high. That cycle is the
//   transfer, and imem_rdata is valid only then. imem_ack is ignored while
//   imem_req is low.
//   inst_valid/dec_ready: Instruction_code and inst_pc stay stable while
//   inst_valid is high. A transfer occurs in any cycle with inst_valid and
//   dec_ready both high.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] Instruction_code;
    logic [31:0] inst_pc;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    // Sequencer side
    modport master (
        output imem_req, imem_addr, inst_valid, Instruction_code, inst_pc,
        input  imem_ack, imem_rdata, dec_ready, redirect, redirect_pc, halt
    );

    // Memory/decode/execute side
    modport slave (
        input  imem_req, imem_addr, inst_valid, Instruction_code, inst_pc,
        output imem_ack, imem_rdata, dec_ready, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer. It owns the PC, issues word requests to
// instruction memory, and holds each returned word until decode accepts it.
// Redirects from execute may arrive at any time, including while a request
// is outstanding.
// Optional macro FETCH_PERF_CNT_EN adds the saturating perf_fetched and
// perf_stall counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] MEM_BYTES = 32'd36
) (
    input  logic                     clk,
    input  logic                     reset,
    fetch_sequencer_if.master        bus,
    output logic [1:0]               o_dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_stall
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic        r_inst_valid;
    logic [31:0] r_inst_code;
    logic [31:0] r_inst_pc;

    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_xfer;

    // Redirect targets are forced word-aligned. The sequential successor
    // wraps to RESET_PC once it would reach the end of memory.
    assign w_target   = bus.redirect_pc & ~32'h3;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_next_pc  = (w_pc_plus4 >= MEM_BYTES) ? RESET_PC : w_pc_plus4;
    assign w_xfer     = r_inst_valid && bus.dec_ready;

    // In FLUSH the request keeps the old address until memory acknowledges it.
    assign bus.imem_req         = (r_state == S_FETCH) || (r_state == S_FLUSH);
    assign bus.imem_addr        = r_pc;
    assign bus.inst_valid       = r_inst_valid;
    assign bus.Instruction_code = r_inst_code;
    assign bus.inst_pc          = r_inst_pc;
    assign o_dbg_state          = r_state;

    // Fetch state machine: PC, pending redirect target and held instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pend_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst_code  <= 32'h0;
            r_inst_pc    <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.redirect) begin
                        r_pc    <= w_target;
                        r_state <= S_FETCH;
                    end else if (!bus.halt) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        if (bus.redirect) begin
                            // Returned word is stale. Restart at the target next cycle.
                            r_pc <= w_target;
                        end else begin
                            r_inst_code  <= bus.imem_rdata;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_VALID;
                        end
                    end else if (bus.redirect) begin
                        // The address must stay stable until ack, so park the target.
                        r_pend_pc <= w_target;
                        r_state   <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (bus.imem_ack) begin
                        r_pc    <= bus.redirect ? w_target : r_pend_pc;
                        r_state <= bus.halt ? S_IDLE : S_FETCH;
                    end else if (bus.redirect) begin
                        r_pend_pc <= w_target;
                    end
                end
                default: begin
                    // S_VALID: r_pc still equals the held instruction's address.
                    if (bus.redirect) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= w_target;
                        r_state      <= S_FETCH;
                    end else if (bus.dec_ready) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= w_next_pc;
                        r_state      <= bus.halt ? S_IDLE : S_FETCH;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    // Saturating transfer and decode-stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= 32'h0;
            r_perf_stall   <= 32'h0;
        end else begin
            if (w_xfer && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (r_inst_valid && !bus.dec_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`else
    logic w_unused_xfer;
    assign w_unused_xfer = w_xfer;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by a
// randomized phase. A small memory model and an instruction-stream reference
// model check the sequencer's behaviour.
module tb_fetch_sequencer;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MEM_BYTES = 36;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_sequencer_if bus();

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (32'(MEM_BYTES))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    // ---------------- model state / scoreboard ----------------
    logic [7:0]  mem_b [0:MEM_BYTES-1];
    logic [31:0] exp_q[$];    // expected inst_pc sequence for the directed run
    logic [31:0] got_q[$];    // transferred inst_pc log
    logic [31:0] code_q[$];   // transferred Instruction_code log
    int          xfer_cyc[$];
    logic [31:0] exp_pc;      // address of the next instruction decode must see
    logic        prev_pend;
    logic [31:0] prev_addr;
    int          mem_cnt;
    int          ack_lat;
    bit          rand_lat;
    int          cycle;
    int          n_tests;
    int          n_fail;
    int          budget;
    int          n0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int ia;
        ia = int'(a);
        if (ia >= 0 && ia + 3 < MEM_BYTES)
            return {mem_b[ia+3], mem_b[ia+2], mem_b[ia+1], mem_b[ia]};
        return 32'h0;
    endfunction

    // Program order: the next word, or back to RESET_PC past the end of memory.
    function automatic logic [31:0] seq_next(input logic [31:0] p);
        return (p + 32'd4 >= 32'(MEM_BYTES)) ? RESET_PC : p + 32'd4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Called #1 after a posedge. It answers memory, checks this cycle against
    // the reference model, then advances to #1 after the next posedge.
    task automatic cyc();
        if (!reset && bus.imem_req === 1'b1) begin
            if (mem_cnt >= ack_lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
            end
        end else begin
            // ack with no request must be ignored
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
        end
        if (reset) begin
            exp_pc    = RESET_PC;
            prev_pend = 1'b0;
            mem_cnt   = 0;
        end else begin
            if (prev_pend) begin
                check("req_held", 32'(bus.imem_req), 32'd1);
                check("addr_held", bus.imem_addr, prev_addr);
            end
            if (bus.imem_req) check("addr_align", bus.imem_addr & 32'h3, 32'h0);
            if (bus.inst_valid) check("no_req_while_valid", 32'(bus.imem_req), 32'd0);
            if (bus.inst_valid && bus.dec_ready) begin
                check("xfer_pc", bus.inst_pc, exp_pc);
                check("xfer_code", bus.Instruction_code, mem_word(exp_pc));
                got_q.push_back(bus.inst_pc);
                code_q.push_back(bus.Instruction_code);
                xfer_cyc.push_back(cycle);
                exp_pc = seq_next(exp_pc);
            end
            if (bus.redirect) exp_pc = bus.redirect_pc & ~32'h3;
            prev_pend = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
            if (bus.imem_req && !bus.imem_ack) mem_cnt++;
            else mem_cnt = 0;
            if (bus.imem_req && bus.imem_ack && rand_lat) ack_lat = $urandom_range(0, 3);
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        got_q.delete();
        code_q.delete();
        xfer_cyc.delete();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] words [0:8];
        n_tests = 0;
        n_fail  = 0;
        cycle   = 0;
        mem_cnt = 0;
        ack_lat = 0;
        rand_lat = 1'b0;
        prev_pend = 1'b0;
        prev_addr = 32'h0;
        exp_pc  = RESET_PC;
        for (int i = 0; i < 9; i++) words[i] = $urandom;
        words[0] = 32'h007302b3;
        words[1] = 32'h41248433;
        words[2] = 32'h01ac9c33;
        words[5] = 32'h013975b3;
        for (int i = 0; i < 9; i++)
            for (int b = 0; b < 4; b++) mem_b[i*4+b] = words[i][b*8 +: 8];

        reset           = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.dec_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.halt        = 1'b0;
        @(posedge clk);
        #1;

        // 1. reset values, first-request timing, sequential run with wrap
        cyc();
        reset = 1'b0;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_code", bus.Instruction_code, 32'h0);
        check("rst_pc", bus.inst_pc, 32'h0);
        got_q.delete();
        cyc();
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, RESET_PC);
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(32'((i * 4) % MEM_BYTES));
        budget = 100;
        while (got_q.size() < 10 && budget > 0) begin
            cyc();
            budget--;
        end
        check("seq_timeout", 32'(budget > 0), 32'd1);
        for (int i = 0; i < 10 && i < got_q.size(); i++) check("seq_pc", got_q[i], exp_q[i]);
        for (int i = 0; i + 1 < xfer_cyc.size(); i++) check("seq_rate", 32'(xfer_cyc[i+1] - xfer_cyc[i]), 32'd2);
        if (code_q.size() >= 2) begin
            check("code_pc0", code_q[0], 32'h007302b3);
            check("code_pc4", code_q[1], 32'h41248433);
        end

        // 2. decode stall holding pc 8
        do_reset();
        budget = 50;
        while (!(bus.inst_valid && bus.inst_pc == 32'd8) && budget > 0) begin
            cyc();
            budget--;
        end
        check("hold_timeout", 32'(budget > 0), 32'd1);
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(bus.inst_valid), 32'd1);
            check("hold_code", bus.Instruction_code, 32'h01ac9c33);
            check("hold_no_req", 32'(bus.imem_req), 32'd0);
            cyc();
        end
        bus.dec_ready = 1'b1;
        check("hold_valid_end", 32'(bus.inst_valid), 32'd1);
        cyc();
        check("after_hold_req", 32'(bus.imem_req), 32'd1);
        check("after_hold_addr", bus.imem_addr, 32'd12);
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall", perf_stall, 32'd5);
        check("perf_fetched", perf_fetched, 32'(got_q.size()));
`endif

        // 3. delayed ack with redirect on the first wait cycle
        do_reset();
        budget = 50;
        while (!(bus.imem_req && bus.imem_addr == 32'd8) && budget > 0) begin
            cyc();
            budget--;
        end
        check("flush_timeout", 32'(budget > 0), 32'd1);
        ack_lat = 3;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'd20;
        cyc();
        bus.redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush_req", 32'(bus.imem_req), 32'd1);
            check("flush_addr", bus.imem_addr, 32'd8);
            cyc();
        end
        ack_lat = 0;
        check("redir_req", 32'(bus.imem_req), 32'd1);
        check("redir_addr", bus.imem_addr, 32'd20);
        cyc();
        check("redir_valid", 32'(bus.inst_valid), 32'd1);
        check("redir_pc", bus.inst_pc, 32'd20);
        check("redir_code", bus.Instruction_code, 32'h013975b3);

        // 4. unaligned redirect in VALID with dec_ready high
        n0 = got_q.size();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h17;
        cyc();
        bus.redirect = 1'b0;
        check("vredir_xfer", 32'(got_q.size()), 32'(n0 + 1));
        check("vredir_req", 32'(bus.imem_req), 32'd1);
        check("vredir_addr", bus.imem_addr, 32'h14);
        cyc();
        check("vredir_pc", bus.inst_pc, 32'h14);

        // 5. reset while a request is outstanding
        ack_lat = 5;
        budget = 20;
        while (!bus.imem_req && budget > 0) begin
            cyc();
            budget--;
        end
        check("rst_out_timeout", 32'(budget > 0), 32'd1);
        cyc();
        reset = 1'b1;
        cyc();
        check("rst_out_req", 32'(bus.imem_req), 32'd0);
        check("rst_out_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_out_code", bus.Instruction_code, 32'h0);
        reset = 1'b0;
        check("rst_out_idle", 32'(bus.imem_req), 32'd0);
        cyc();
        check("rst_out_req2", 32'(bus.imem_req), 32'd1);
        check("rst_out_addr", bus.imem_addr, RESET_PC);
        ack_lat = 0;

        // 6. randomized traffic against the reference model
        rand_lat = 1'b1;
        got_q.delete();
        for (int i = 0; i < 1500; i++) begin
            bus.dec_ready   = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 9) == 0);
            bus.redirect_pc = 32'($urandom_range(0, MEM_BYTES - 1));
            bus.halt        = ($urandom_range(0, 15) == 0);
            reset           = ($urandom_range(0, 299) == 0);
            cyc();
        end
        reset        = 1'b0;
        bus.redirect = 1'b0;
        bus.halt     = 1'b0;
        check("rand_progress", 32'(got_q.size() > 20), 32'd1);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
